// File: rtl/icache_dm_line.sv
// Direct-mapped instruction cache with multi-word lines, sequential ascending refill,
// whole-cache flush and free-running hit/miss counters.
module icache_dm_line #(
  parameter int ADDR_W      = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              cache_call_begin,
  input  logic [ADDR_W-1:0] pc,
  output logic              cache_return_ready,
  output logic [31:0]       cache_return_instruction,
  output logic              inst_interface_call_begin,
  output logic [ADDR_W-1:0] inst_interface_addr,
  input  logic              inst_interface_return_ready,
  input  logic [31:0]       inst_interface_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
  localparam int KW    = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
  localparam int DW    = INDEX_BITS + KW;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       req_pc;
  logic [KW-1:0]           k;
  logic [31:0]             resp_word;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES*WORDS];

  logic [KW-1:0]           pc_off, l_off;
  logic [INDEX_BITS-1:0]   pc_idx, l_idx;
  logic [TAG_W-1:0]        pc_tag, l_tag;
  logic                    hit, k_last, k_is_off, ret;

  function automatic logic [KW-1:0] off_of(input logic [ADDR_W-1:0] a);
    return (OFFSET_BITS > 0) ? KW'(a >> 2) : '0;
  endfunction

  function automatic logic [DW-1:0] daddr(input logic [INDEX_BITS-1:0] idx,
                                          input logic [KW-1:0] w);
    return (DW'(idx) << OFFSET_BITS) | DW'(w);
  endfunction

  // Word address inside the line containing a, with word-in-line replaced by w.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [KW-1:0] w);
    return ((a >> (OFFSET_BITS + 2)) << (OFFSET_BITS + 2)) | (ADDR_W'(w) << 2);
  endfunction

  assign pc_off   = off_of(pc);
  assign pc_idx   = INDEX_BITS'(pc >> (OFFSET_BITS + 2));
  assign pc_tag   = TAG_W'(pc >> (INDEX_BITS + OFFSET_BITS + 2));
  assign l_off    = off_of(req_pc);
  assign l_idx    = INDEX_BITS'(req_pc >> (OFFSET_BITS + 2));
  assign l_tag    = TAG_W'(req_pc >> (INDEX_BITS + OFFSET_BITS + 2));
  assign hit      = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign k_last   = (k == KW'(WORDS - 1));
  assign k_is_off = (k == l_off);
  assign ret      = (state == WAIT) && inst_interface_return_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                     <= IDLE;
      req_pc                    <= '0;
      k                         <= '0;
      resp_word                 <= '0;
      valid                     <= '0;
      cache_return_ready        <= 1'b0;
      cache_return_instruction  <= '0;
      inst_interface_call_begin <= 1'b0;
      inst_interface_addr       <= '0;
      hit_count                 <= '0;
      miss_count                <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (enable && cache_call_begin) begin
            req_pc <= pc;
            if (hit) begin
              state                    <= RESP;
              cache_return_ready       <= 1'b1;
              cache_return_instruction <= data_mem[daddr(pc_idx, pc_off)];
              hit_count                <= hit_count + 1'b1;
            end else begin
              state                     <= REQ;
              k                         <= '0;
              valid[pc_idx]             <= 1'b0;
              miss_count                <= miss_count + 1'b1;
              inst_interface_call_begin <= 1'b1;
              inst_interface_addr       <= word_addr(pc, '0);
            end
          end
        end
        REQ: begin
          inst_interface_call_begin <= 1'b0;
          inst_interface_addr       <= '0;
          state                     <= WAIT;
        end
        WAIT: begin
          if (inst_interface_return_ready) begin
            if (k_is_off) resp_word <= inst_interface_rdata;
            if (k_last) begin
              valid[l_idx]             <= 1'b1;
              state                    <= RESP;
              cache_return_ready       <= 1'b1;
              cache_return_instruction <= k_is_off ? inst_interface_rdata : resp_word;
            end else begin
              k                         <= k + 1'b1;
              state                     <= REQ;
              inst_interface_call_begin <= 1'b1;
              inst_interface_addr       <= word_addr(req_pc, k + 1'b1);
            end
          end
        end
        default: begin
          cache_return_ready       <= 1'b0;
          cache_return_instruction <= '0;
          state                    <= IDLE;
        end
      endcase
    end
  end

  // NOTE: data/tag arrays are left unreset on purpose; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (ret) begin
      data_mem[daddr(l_idx, k)] <= inst_interface_rdata;
      if (k_last) tag_mem[l_idx] <= l_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm_line.sv
// Randomised bench for icache_dm_line: a bus responder with random latency and a
// line-level cache model (copy of memory at fill time) predicting every response.
module tb_icache_dm_line;

  logic        clk = 1'b0;
  logic        reset, enable, flush, cache_call_begin;
  logic [31:0] pc;
  logic        cache_return_ready;
  logic [31:0] cache_return_instruction;
  logic        inst_interface_call_begin;
  logic [31:0] inst_interface_addr;
  logic        inst_interface_return_ready;
  logic [31:0] inst_interface_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  icache_dm_line dut (
    .clk                         (clk),
    .reset                       (reset),
    .enable                      (enable),
    .flush                       (flush),
    .cache_call_begin            (cache_call_begin),
    .pc                          (pc),
    .cache_return_ready          (cache_return_ready),
    .cache_return_instruction    (cache_return_instruction),
    .inst_interface_call_begin   (inst_interface_call_begin),
    .inst_interface_addr         (inst_interface_addr),
    .inst_interface_return_ready (inst_interface_return_ready),
    .inst_interface_rdata        (inst_interface_rdata),
    .hit_count                   (hit_count),
    .miss_count                  (miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: 64 lines of 4 words, filled from memory when a miss is predicted.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  int          m_hits, m_misses;
  int          mode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mode == 0) return 32'hA0 + ((a >> 2) & 32'h3);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  // Bus responder: answers each call_begin after 1+extra..3+extra cycles.
  logic [31:0] addr_q[$];
  int          ret_cnt = 0;
  bit          pend = 1'b0;
  int          pend_delay = 0;
  int          extra = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    inst_interface_return_ready = 1'b0;
    inst_interface_rdata        = '0;
    forever begin
      @(negedge clk);
      inst_interface_return_ready = 1'b0;
      inst_interface_rdata        = '0;
      if (pend) begin
        if (pend_delay == 0) begin
          inst_interface_return_ready = 1'b1;
          inst_interface_rdata        = mem_word(pend_addr);
          pend = 1'b0;
          ret_cnt++;
        end else begin
          pend_delay--;
        end
      end
      if (inst_interface_call_begin === 1'b1) begin
        addr_q.push_back(inst_interface_addr);
        pend       = 1'b1;
        pend_delay = $urandom_range(0, 2) + extra;
        pend_addr  = inst_interface_addr;
      end
    end
  end

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, hit_count, m_hits);
    check({tag, "_misses"}, miss_count, m_misses);
  endtask

  // One CPU fetch. If call_begin is already being held, the request continues this cycle.
  task automatic do_fetch(input logic [31:0] a);
    int          idx, off, cycles;
    logic [31:0] tg, base, exp;
    bit          is_hit, got;
    idx    = int'((a >> 4) & 32'h3F);
    off    = int'((a >> 2) & 32'h3);
    tg     = a >> 10;
    base   = a & ~32'hF;
    is_hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!cache_call_begin) @(negedge clk);
    cache_call_begin = 1'b1;
    pc               = a;
    cycles = 0;
    got    = 1'b0;
    while (cycles < 100 && !got) begin
      @(negedge clk);
      cycles++;
      if (cache_return_ready) got = 1'b1;
    end
    cache_call_begin = 1'b0;
    if (is_hit) begin
      m_hits++;
    end else begin
      m_misses++;
      for (int w = 0; w < 4; w++) m_data[idx][w] = mem_word(base + 32'(4 * w));
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    exp = m_data[idx][off];
    check("ready_seen", got, 1);
    if (got) check("instr", cache_return_instruction, exp);
    if (is_hit) check("hit_latency", cycles, 1);
    check("traffic_n", addr_q.size(), is_hit ? 0 : 4);
    if (!is_hit)
      for (int w = 0; w < addr_q.size() && w < 4; w++)
        check("traffic_addr", addr_q[w], base + 32'(4 * w));
    addr_q.delete();
    check_counts("cnt");
    @(negedge clk);
    check("ready_pulse", cache_return_ready, 0);
    check("instr_idle", cache_return_instruction, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          n, r0;
    logic [31:0] p;
    mode = 0; m_hits = 0; m_misses = 0;
    model_clear();
    reset = 1'b1; enable = 1'b1; flush = 1'b0; cache_call_begin = 1'b0; pc = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", cache_return_ready, 0);
    check("rst_instr", cache_return_instruction, 0);
    check("rst_icb", inst_interface_call_begin, 0);
    check("rst_iaddr", inst_interface_addr, 0);
    check_counts("rst");
    reset = 1'b0;

    // Cold miss, hit in same line, conflict misses on index 0.
    do_fetch(32'h1000_0008);
    do_fetch(32'h1000_000C);
    do_fetch(32'h1000_0408);
    do_fetch(32'h1000_0008);
    check("three_misses", miss_count, 3);
    do_fetch(32'h1000_0010);

    // Flush together with a request: not accepted that cycle, accepted the next.
    @(negedge clk);
    flush = 1'b1; cache_call_begin = 1'b1; pc = 32'h1000_0400;
    @(negedge clk);
    check("flush_no_ready", cache_return_ready, 0);
    check("flush_no_icb", inst_interface_call_begin, 0);
    check_counts("flush");
    model_clear();
    flush = 1'b0;
    do_fetch(32'h1000_0400);
    do_fetch(32'h1000_0010);
    do_fetch(32'h1000_0404);

    // enable low blocks acceptance; raising it accepts on the next edge.
    enable = 1'b0;
    @(negedge clk);
    cache_call_begin = 1'b1; pc = 32'h1000_0404;
    repeat (5) begin
      @(negedge clk);
      check("en0_ready", cache_return_ready, 0);
      check("en0_icb", inst_interface_call_begin, 0);
    end
    check("en0_traffic", addr_q.size(), 0);
    check_counts("en0");
    enable = 1'b1;
    do_fetch(32'h1000_0404);

    // Reset after two of four words of a refill.
    p = 32'h1000_0020;
    extra = 3;
    r0 = ret_cnt;
    @(negedge clk);
    cache_call_begin = 1'b1; pc = p;
    n = 0;
    while (ret_cnt < r0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_progress", ret_cnt >= r0 + 2, 1);
    @(posedge clk);
    #1;
    reset = 1'b1; cache_call_begin = 1'b0;
    #1;
    check("rstm_ready", cache_return_ready, 0);
    check("rstm_instr", cache_return_instruction, 0);
    check("rstm_icb", inst_interface_call_begin, 0);
    check("rstm_iaddr", inst_interface_addr, 0);
    m_hits = 0; m_misses = 0;
    model_clear();
    check_counts("rstm");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    pend = 1'b1; pend_delay = 0; pend_addr = p;
    repeat (4) begin
      @(negedge clk);
      check("stray_ready", cache_return_ready, 0);
      check("stray_icb", inst_interface_call_begin, 0);
    end
    check_counts("stray");
    extra = 0;
    addr_q.delete();
    do_fetch(p);
    do_fetch(32'h1000_000C);

    // Randomised traffic over 4 tags x 8 lines, with occasional flushes.
    mode = 1;
    repeat (200) begin
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end else begin
        p = 32'h2000_0000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 7) << 4)
            + ($urandom_range(0, 3) << 2);
        do_fetch(p);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
